stim_gen: RTL and testbench

Operand stimulus generator for the arithmetic testbench. It is the driving end of the DUT operand interface: it produces the `a`/`b` operand pairs that feed both the DUT and the checking monitor, one vector per clock. Four pattern modes are available: pseudo-random, walking-one, corner sweep and exhaustive count. A start/done handshake brackets each run so that a controller can sequence the tests.

---
 rtl/stim_gen_if.sv | 27 ++
 rtl/stim_gen.sv | 165 ++++++++++++++++
 tb/tb_stim_gen.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stim_gen_if.sv
// Operand-stimulus bus: control from the test controller in, operand vectors out.
// The master side is the generator; the slave side is the controller/monitor.
interface stim_gen_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_mode;
    logic [31:0]      i_count;
    logic             i_hold;
    logic             i_stop;
    logic [WIDTH-1:0] o_dut_ia;
    logic [WIDTH-1:0] o_dut_ib;
    logic             o_valid;
    logic [31:0]      o_vec_idx;
    logic             o_busy;
    logic             o_done;

    modport master (
        input  i_start, i_mode, i_count, i_hold, i_stop,
        output o_dut_ia, o_dut_ib, o_valid, o_vec_idx, o_busy, o_done
    );

    modport slave (
        output i_start, i_mode, i_count, i_hold, i_stop,
        input  o_dut_ia, o_dut_ib, o_valid, o_vec_idx, o_busy, o_done
    );
endinterface

// File: rtl/stim_gen.sv
// Operand stimulus generator: random / walking-one / corner / exhaustive vectors,
// one per clock, bracketed by a start/done handshake.
module stim_gen #(
    parameter int          WIDTH = 32,
    parameter logic [31:0] SEED  = 32'hACE1_2024
) (
    input  logic       clk,
    input  logic       reset,
    stim_gen_if.master bus
);
    localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]   SEED_B    = SEED ^ 32'h5A5A_5A5A;
    localparam int            KW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST    = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Generator state describes the vector currently on the outputs.
    typedef struct packed {
        logic [31:0]        lfsr_a;
        logic [31:0]        lfsr_b;
        logic [KW-1:0]      walk_k;
        logic [2*WIDTH-1:0] ex_cnt;
    } gen_t;

    localparam gen_t GEN_INIT = '{lfsr_a: SEED, lfsr_b: SEED_B, walk_k: '0, ex_cnt: '0};

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    function automatic gen_t gen_step(input gen_t g);
        gen_t n;
        n.lfsr_a = lfsr_step(g.lfsr_a);
        n.lfsr_b = lfsr_step(g.lfsr_b);
        n.walk_k = (g.walk_k == K_LAST) ? '0 : g.walk_k + KW'(1);
        n.ex_cnt = g.ex_cnt + (2*WIDTH)'(1);
        return n;
    endfunction

    // Returns {B, A} for the given mode; ci is the low nibble of the vector index.
    function automatic logic [2*WIDTH-1:0] vec_of(input logic [1:0] mode, input gen_t g,
                                                  input logic [3:0] ci);
        logic [3:0][WIDTH-1:0] corner;
        logic [WIDTH-1:0]      a;
        logic [WIDTH-1:0]      b;
        corner[0] = '0;
        corner[1] = WIDTH'(1);
        corner[2] = '1;
        corner[3] = WIDTH'(1) << (WIDTH - 1);
        case (mode)
            2'b00: begin
                a = g.lfsr_a[WIDTH-1:0];
                b = g.lfsr_b[WIDTH-1:0];
            end
            2'b01: begin
                a = WIDTH'(1) << g.walk_k;
                b = ~a;
            end
            2'b10: begin
                a = corner[ci[3:2]];
                b = corner[ci[1:0]];
            end
            default: begin
                a = g.ex_cnt[WIDTH-1:0];
                b = g.ex_cnt[2*WIDTH-1:WIDTH];
            end
        endcase
        return {b, a};
    endfunction

    state_t           state, state_nxt;
    logic [1:0]       mode_q, mode_nxt;
    logic [31:0]      count_q, count_nxt;
    gen_t             gen_q, gen_nxt, gen_adv;
    logic [WIDTH-1:0] ia_q, ia_nxt;
    logic [WIDTH-1:0] ib_q, ib_nxt;
    logic             valid_q, valid_nxt;
    logic [31:0]      idx_q, idx_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            mode_q  <= '0;
            count_q <= '0;
            gen_q   <= GEN_INIT;
            ia_q    <= '0;
            ib_q    <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            mode_q  <= mode_nxt;
            count_q <= count_nxt;
            gen_q   <= gen_nxt;
            ia_q    <= ia_nxt;
            ib_q    <= ib_nxt;
            valid_q <= valid_nxt;
            idx_q   <= idx_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        count_nxt = count_q;
        gen_nxt   = gen_q;
        ia_nxt    = ia_q;
        ib_nxt    = ib_q;
        valid_nxt = 1'b0;
        idx_nxt   = idx_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        gen_adv   = gen_step(gen_q);
        // A zero count never terminates; idx simply wraps.
        last      = (count_q != '0) && (idx_q == count_q - 32'd1);

        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt        = RUN;
                    mode_nxt         = bus.i_mode;
                    count_nxt        = bus.i_count;
                    gen_nxt          = GEN_INIT;
                    idx_nxt          = '0;
                    {ib_nxt, ia_nxt} = vec_of(bus.i_mode, GEN_INIT, 4'd0);
                    valid_nxt        = 1'b1;
                    busy_nxt         = 1'b1;
                end
            end
            RUN: begin
                if (bus.i_stop || last) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else if (!bus.i_hold) begin
                    gen_nxt          = gen_adv;
                    idx_nxt          = idx_q + 32'd1;
                    {ib_nxt, ia_nxt} = vec_of(mode_q, gen_adv, idx_nxt[3:0]);
                    valid_nxt        = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_dut_ia  = ia_q;
    assign bus.o_dut_ib  = ib_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_vec_idx = idx_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
endmodule

// File: tb/tb_stim_gen.sv
// Bench for stim_gen: an 8-bit and a 32-bit instance checked against a
// vector-index-based reference model, directed scenarios plus random traffic.
module tb_stim_gen;
    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    stim_gen_if #(.WIDTH(8))  b8 ();
    stim_gen_if #(.WIDTH(32)) b32 ();

    stim_gen #(.WIDTH(8),  .SEED(SEED)) dut8  (.clk(clk), .reset(reset), .bus(b8));
    stim_gen #(.WIDTH(32), .SEED(SEED)) dut32 (.clk(clk), .reset(reset), .bus(b32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] fb;
        fb = s[0] ? POLY : 32'h0;
        return {1'b0, s[31:1]} ^ fb;
    endfunction

    // Expected operands of vector i for a w-bit generator in mode m.
    function automatic void exp_vec(input int w, input logic [1:0] m, input int i,
                                    output logic [31:0] a, output logic [31:0] b);
        logic [31:0] msk, sa, sb;
        logic [63:0] v;
        logic [31:0] c [4];
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        case (m)
            2'b00: begin
                sa = SEED;
                sb = SEED ^ 32'h5A5A_5A5A;
                for (int s = 0; s < i; s++) begin
                    sa = lfsr_next(sa);
                    sb = lfsr_next(sb);
                end
                a = sa & msk;
                b = sb & msk;
            end
            2'b01: begin
                a = 32'h1 << (i % w);
                b = ~a & msk;
            end
            2'b10: begin
                c[0] = 32'h0;
                c[1] = 32'h1;
                c[2] = msk;
                c[3] = 32'h1 << (w - 1);
                a = c[(i >> 2) & 3];
                b = c[i & 3];
            end
            default: begin
                v = 64'(i);
                a = v[31:0] & msk;
                b = 32'(v >> w) & msk;
            end
        endcase
    endfunction

    task automatic start8(input logic [1:0] m, input logic [31:0] c);
        b8.i_mode  = m;
        b8.i_count = c;
        b8.i_start = 1'b1;
        @(negedge clk);
        b8.i_start = 1'b0;
    endtask

    task automatic start32(input logic [1:0] m, input logic [31:0] c);
        b32.i_mode  = m;
        b32.i_count = c;
        b32.i_start = 1'b1;
        @(negedge clk);
        b32.i_start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b8.o_dut_ia, b8.o_dut_ib, b8.o_valid, b8.o_vec_idx, b8.o_busy, b8.o_done} !== 52'h0) begin
            failures++;
            $display("FAIL reset8: got a=%h b=%h v=%b idx=%0d busy=%b done=%b, expected all 0",
                     b8.o_dut_ia, b8.o_dut_ib, b8.o_valid, b8.o_vec_idx, b8.o_busy, b8.o_done);
        end
        checks++;
        if ({b32.o_dut_ia, b32.o_dut_ib, b32.o_valid, b32.o_vec_idx, b32.o_busy, b32.o_done} !== 100'h0) begin
            failures++;
            $display("FAIL reset32: got a=%h b=%h v=%b idx=%0d busy=%b done=%b, expected all 0",
                     b32.o_dut_ia, b32.o_dut_ib, b32.o_valid, b32.o_vec_idx, b32.o_busy, b32.o_done);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({b8.o_valid, b8.o_busy, b8.o_done} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset: got v/busy/done=%b, expected 000",
                     {b8.o_valid, b8.o_busy, b8.o_done});
        end
    endtask

    task automatic test_walking;
        logic [31:0] ea, eb;
        logic [7:0]  seq [10];
        logic [7:0]  lit [10];
        lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        start8(2'b01, 32'd10);
        for (int i = 0; i < 10; i++) begin
            exp_vec(8, 2'b01, i, ea, eb);
            seq[i] = b8.o_dut_ia;
            checks++;
            if ({b8.o_valid, b8.o_busy, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !==
                {1'b1, 1'b1, 32'(i), ea[7:0], eb[7:0]}) begin
                failures++;
                $display("FAIL walk_vec%0d: got v=%b busy=%b idx=%0d a=%h b=%h, expected a=%h b=%h",
                         i, b8.o_valid, b8.o_busy, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib, ea[7:0], eb[7:0]);
            end
            // A start pulse mid-run with different mode/count must be ignored.
            b8.i_start = (i == 4);
            b8.i_mode  = (i == 4) ? 2'b11 : 2'b01;
            b8.i_count = (i == 4) ? 32'd2 : 32'd10;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (seq[i] !== lit[i]) begin
                failures++;
                $display("FAIL walk_seq%0d: got %h expected %h", i, seq[i], lit[i]);
            end
        end
        checks++;
        if ({b8.o_valid, b8.o_done, b8.o_busy, b8.o_dut_ia, b8.o_dut_ib} !== {3'b010, 8'h02, 8'hFD}) begin
            failures++;
            $display("FAIL walk_done: got v=%b done=%b busy=%b a=%h b=%h, expected 0 1 0 02 FD",
                     b8.o_valid, b8.o_done, b8.o_busy, b8.o_dut_ia, b8.o_dut_ib);
        end
        @(negedge clk);
        checks++;
        if ({b8.o_valid, b8.o_done, b8.o_busy} !== 3'b000) begin
            failures++;
            $display("FAIL walk_idle: got v/done/busy=%b expected 000", {b8.o_valid, b8.o_done, b8.o_busy});
        end
    endtask

    task automatic test_corner;
        logic [31:0] ea, eb;
        logic [15:0] run1 [16];
        for (int r = 0; r < 2; r++) begin
            start8(2'b10, 32'd16);
            for (int i = 0; i < 16; i++) begin
                exp_vec(8, 2'b10, i, ea, eb);
                checks++;
                if ({b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {1'b1, 32'(i), ea[7:0], eb[7:0]}) begin
                    failures++;
                    $display("FAIL corner_r%0d_v%0d: got v=%b idx=%0d a=%h b=%h, expected a=%h b=%h",
                             r, i, b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib, ea[7:0], eb[7:0]);
                end
                if (r == 0) begin
                    run1[i] = {b8.o_dut_ia, b8.o_dut_ib};
                end else begin
                    checks++;
                    if ({b8.o_dut_ia, b8.o_dut_ib} !== run1[i]) begin
                        failures++;
                        $display("FAIL corner_rerun%0d: got %h expected %h", i, {b8.o_dut_ia, b8.o_dut_ib}, run1[i]);
                    end
                end
                @(negedge clk);
            end
            checks++;
            if ({b8.o_valid, b8.o_done} !== 2'b01) begin
                failures++;
                $display("FAIL corner_done: got v/done=%b expected 01", {b8.o_valid, b8.o_done});
            end
            @(negedge clk);
        end
        checks++;
        if ({run1[2], run1[3], run1[6], run1[15]} !== {16'h00FF, 16'h0080, 16'h01FF, 16'h8080}) begin
            failures++;
            $display("FAIL corner_literal: got %h %h %h %h expected 00FF 0080 01FF 8080",
                     run1[2], run1[3], run1[6], run1[15]);
        end
    endtask

    task automatic test_exhaustive;
        logic [31:0] ea, eb;
        start8(2'b11, 32'd300);
        for (int i = 0; i < 300; i++) begin
            exp_vec(8, 2'b11, i, ea, eb);
            checks++;
            if ({b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {1'b1, 32'(i), ea[7:0], eb[7:0]}) begin
                failures++;
                $display("FAIL exh_v%0d: got v=%b idx=%0d a=%h b=%h, expected a=%h b=%h",
                         i, b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib, ea[7:0], eb[7:0]);
            end
            if (i == 255 || i == 256 || i == 299) begin
                checks++;
                if ({b8.o_dut_ia, b8.o_dut_ib} !== ((i == 255) ? 16'hFF00 : (i == 256) ? 16'h0001 : 16'h2B01)) begin
                    failures++;
                    $display("FAIL exh_literal%0d: got a=%h b=%h", i, b8.o_dut_ia, b8.o_dut_ib);
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({b8.o_valid, b8.o_done} !== 2'b01) begin
            failures++;
            $display("FAIL exh_done: got v/done=%b expected 01", {b8.o_valid, b8.o_done});
        end
        @(negedge clk);
    endtask

    task automatic test_random_mode;
        logic [31:0] ea, eb;
        logic [63:0] run1 [4];
        for (int r = 0; r < 2; r++) begin
            start32(2'b00, 32'd4);
            checks++;
            if ({b32.o_dut_ia, b32.o_dut_ib} !== {32'hACE1_2024, 32'hF6BB_7A7E}) begin
                failures++;
                $display("FAIL rand_vec0: got a=%h b=%h expected ACE12024 F6BB7A7E", b32.o_dut_ia, b32.o_dut_ib);
            end
            for (int i = 0; i < 4; i++) begin
                exp_vec(32, 2'b00, i, ea, eb);
                checks++;
                if ({b32.o_valid, b32.o_vec_idx, b32.o_dut_ia, b32.o_dut_ib} !== {1'b1, 32'(i), ea, eb}) begin
                    failures++;
                    $display("FAIL rand_r%0d_v%0d: got v=%b idx=%0d a=%h b=%h, expected a=%h b=%h",
                             r, i, b32.o_valid, b32.o_vec_idx, b32.o_dut_ia, b32.o_dut_ib, ea, eb);
                end
                checks++;
                if (b32.o_dut_ia == 32'h0 || b32.o_dut_ib == 32'h0) begin
                    failures++;
                    $display("FAIL rand_zero%0d: got a=%h b=%h, expected both nonzero", i, b32.o_dut_ia, b32.o_dut_ib);
                end
                if (r == 0) begin
                    run1[i] = {b32.o_dut_ia, b32.o_dut_ib};
                end else begin
                    checks++;
                    if ({b32.o_dut_ia, b32.o_dut_ib} !== run1[i]) begin
                        failures++;
                        $display("FAIL rand_rerun%0d: got %h expected %h", i, {b32.o_dut_ia, b32.o_dut_ib}, run1[i]);
                    end
                end
                @(negedge clk);
            end
            checks++;
            if ({b32.o_valid, b32.o_done} !== 2'b01) begin
                failures++;
                $display("FAIL rand_done: got v/done=%b expected 01", {b32.o_valid, b32.o_done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold;
        start8(2'b01, 32'd6);
        repeat (2) @(negedge clk);
        b8.i_hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            checks++;
            if ({b8.o_valid, b8.o_busy, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {2'b01, 32'd2, 8'h04, 8'hFB}) begin
                failures++;
                $display("FAIL hold%0d: got v=%b busy=%b idx=%0d a=%h b=%h, expected 0 1 2 04 FB",
                         h, b8.o_valid, b8.o_busy, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib);
            end
        end
        b8.i_hold = 1'b0;
        @(negedge clk);
        checks++;
        if ({b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {1'b1, 32'd3, 8'h08, 8'hF7}) begin
            failures++;
            $display("FAIL hold_release: got v=%b idx=%0d a=%h b=%h, expected 1 3 08 F7",
                     b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({b8.o_valid, b8.o_done} !== 2'b01) begin
            failures++;
            $display("FAIL hold_done: got v/done=%b expected 01", {b8.o_valid, b8.o_done});
        end
        @(negedge clk);
    endtask

    task automatic test_stop_freerun;
        logic [31:0] ea, eb;
        start8(2'b00, 32'd0);
        repeat (5) @(negedge clk);
        exp_vec(8, 2'b00, 5, ea, eb);
        checks++;
        if ({b8.o_valid, b8.o_vec_idx} !== {1'b1, 32'd5}) begin
            failures++;
            $display("FAIL stop_pre: got v=%b idx=%0d expected 1 5", b8.o_valid, b8.o_vec_idx);
        end
        b8.i_stop = 1'b1;
        b8.i_hold = 1'b1;
        @(negedge clk);
        b8.i_stop = 1'b0;
        b8.i_hold = 1'b0;
        checks++;
        if ({b8.o_valid, b8.o_done, b8.o_busy} !== 3'b010) begin
            failures++;
            $display("FAIL stop_done: got v/done/busy=%b expected 010", {b8.o_valid, b8.o_done, b8.o_busy});
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({b8.o_valid, b8.o_done, b8.o_busy, b8.o_dut_ia, b8.o_dut_ib} !== {3'b000, ea[7:0], eb[7:0]}) begin
                failures++;
                $display("FAIL stop_idle%0d: got v=%b done=%b busy=%b a=%h b=%h, expected 0 0 0 %h %h",
                         c, b8.o_valid, b8.o_done, b8.o_busy, b8.o_dut_ia, b8.o_dut_ib, ea[7:0], eb[7:0]);
            end
        end
    endtask

    task automatic test_reset_midrun;
        start8(2'b11, 32'd20);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({b8.o_dut_ia, b8.o_dut_ib, b8.o_valid, b8.o_vec_idx, b8.o_busy, b8.o_done} !== 52'h0) begin
            failures++;
            $display("FAIL reset_mid: got a=%h b=%h v=%b idx=%0d busy=%b done=%b, expected all 0",
                     b8.o_dut_ia, b8.o_dut_ib, b8.o_valid, b8.o_vec_idx, b8.o_busy, b8.o_done);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({b8.o_valid, b8.o_done, b8.o_busy} !== 3'b000) begin
                failures++;
                $display("FAIL reset_mid_quiet%0d: got v/done/busy=%b expected 000",
                         c, {b8.o_valid, b8.o_done, b8.o_busy});
            end
        end
    endtask

    // Random mode/count with random hold and stop; the model tracks only the
    // current vector index and whether the run has ended.
    task automatic test_random_traffic;
        logic [31:0] ea, eb;
        logic [1:0]  m;
        int          c, n, guard;
        bit          fin, hold, stop;
        for (int it = 0; it < 16; it++) begin
            m = 2'($urandom_range(0, 3));
            c = $urandom_range(1, 30);
            start8(m, 32'(c));
            n = 0;
            exp_vec(8, m, 0, ea, eb);
            checks++;
            if ({b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {1'b1, 32'd0, ea[7:0], eb[7:0]}) begin
                failures++;
                $display("FAIL rt%0d_v0: got v=%b idx=%0d a=%h b=%h, expected a=%h b=%h",
                         it, b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib, ea[7:0], eb[7:0]);
            end
            fin   = 1'b0;
            guard = 0;
            while (!fin && guard < 200) begin
                hold = ($urandom_range(0, 3) == 0);
                stop = ($urandom_range(0, 31) == 0);
                b8.i_hold = hold;
                b8.i_stop = stop;
                @(negedge clk);
                guard++;
                if (stop || n == c - 1) begin
                    fin = 1'b1;
                    checks++;
                    if ({b8.o_valid, b8.o_done, b8.o_busy, b8.o_vec_idx} !== {3'b010, 32'(n)}) begin
                        failures++;
                        $display("FAIL rt%0d_end: got v=%b done=%b busy=%b idx=%0d, expected 0 1 0 %0d",
                                 it, b8.o_valid, b8.o_done, b8.o_busy, b8.o_vec_idx, n);
                    end
                end else if (hold) begin
                    checks++;
                    if ({b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {1'b0, 32'(n), ea[7:0], eb[7:0]}) begin
                        failures++;
                        $display("FAIL rt%0d_hold: got v=%b idx=%0d a=%h b=%h, expected 0 %0d %h %h",
                                 it, b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib, n, ea[7:0], eb[7:0]);
                    end
                end else begin
                    n++;
                    exp_vec(8, m, n, ea, eb);
                    checks++;
                    if ({b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib} !== {1'b1, 32'(n), ea[7:0], eb[7:0]}) begin
                        failures++;
                        $display("FAIL rt%0d_v%0d: got v=%b idx=%0d a=%h b=%h, expected a=%h b=%h",
                                 it, n, b8.o_valid, b8.o_vec_idx, b8.o_dut_ia, b8.o_dut_ib, ea[7:0], eb[7:0]);
                    end
                end
            end
            b8.i_hold = 1'b0;
            b8.i_stop = 1'b0;
            if (!fin) begin
                checks++;
                failures++;
                $display("FAIL rt%0d_timeout: run did not end within %0d cycles", it, guard);
            end
            @(negedge clk);
            checks++;
            if ({b8.o_valid, b8.o_done, b8.o_busy} !== 3'b000) begin
                failures++;
                $display("FAIL rt%0d_idle: got v/done/busy=%b expected 000", it, {b8.o_valid, b8.o_done, b8.o_busy});
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        b8.i_start  = 1'b0;
        b8.i_mode   = 2'b00;
        b8.i_count  = 32'd0;
        b8.i_hold   = 1'b0;
        b8.i_stop   = 1'b0;
        b32.i_start = 1'b0;
        b32.i_mode  = 2'b00;
        b32.i_count = 32'd0;
        b32.i_hold  = 1'b0;
        b32.i_stop  = 1'b0;
        @(negedge clk);
        test_reset;
        test_walking;
        test_corner;
        test_exhaustive;
        test_random_mode;
        test_hold;
        test_stop_freerun;
        test_reset_midrun;
        test_random_traffic;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
